// File: rtl/bit_reverse_pkg.sv
// Shared constants and lane-index helpers for the bit_reverse NTT reorder block.
// Lane index layout: {pair[3:0], bit}; pair rotation never touches the low bit.
package bit_reverse_pkg;

    localparam int PE_NUMBER_DEF     = 32;
    localparam int DATA_SIZE_ARB_DEF = 64;
    localparam int PAIR_BITS         = 4;
    localparam int LANE_BITS         = PAIR_BITS + 1;
    localparam int PAIR_COUNT        = 1 << PAIR_BITS;

    // 5-bit reversal: swaps index bits 0<->4 and 1<->3, bit 2 stays.
    function automatic logic [LANE_BITS-1:0] bitrev5(input logic [LANE_BITS-1:0] idx);
        return {idx[0], idx[1], idx[2], idx[3], idx[4]};
    endfunction

    // Destination lane of input lane i after un-skewing by cycle (pair index wraps mod 16).
    function automatic logic [LANE_BITS-1:0] rot_idx(input logic [LANE_BITS-1:0] i,
                                                     input logic [PAIR_BITS-1:0] cycle);
        logic [PAIR_BITS-1:0] pair;
        pair = i[LANE_BITS-1:1] + cycle;
        return {pair, i[0]};
    endfunction

endpackage

// File: rtl/bit_reverse_pair_rotate.sv
// pair_rotate: combinational un-skew network, each output lane is a 16-way mux on cycle.
// Candidate table is built by scattering every source lane for every cycle value.
module pair_rotate
    import bit_reverse_pkg::*;
#(
    parameter int DATA_SIZE_ARB = DATA_SIZE_ARB_DEF,
    parameter int PE_NUMBER     = PE_NUMBER_DEF
) (
    input  logic [PAIR_BITS-1:0]               cycle,
    input  logic [DATA_SIZE_ARB*PE_NUMBER-1:0] data_in,
    output logic [DATA_SIZE_ARB*PE_NUMBER-1:0] data_out
);

    // cand[d][c]: the input lane that lands on lane d when the rotation is c.
    logic [DATA_SIZE_ARB-1:0] cand [PE_NUMBER][PAIR_COUNT];

    for (genvar c = 0; c < PAIR_COUNT; c++) begin : g_cyc
        for (genvar i = 0; i < PE_NUMBER; i++) begin : g_src
            localparam logic [LANE_BITS-1:0] DST = rot_idx(LANE_BITS'(i), PAIR_BITS'(c));
            assign cand[DST][c] = data_in[i*DATA_SIZE_ARB +: DATA_SIZE_ARB];
        end
    end

    for (genvar d = 0; d < PE_NUMBER; d++) begin : g_dst
        assign data_out[d*DATA_SIZE_ARB +: DATA_SIZE_ARB] = cand[d][cycle];
    end

endmodule

// File: rtl/bit_reverse.sv
// bit_reverse: registers a 32-lane word with its cycle, un-skews pairs, then bit-reverses lanes.
// Define BITREV_OUT_REG_EN to add an output register (latency 2 instead of 1).
module bit_reverse
    import bit_reverse_pkg::*;
#(
    parameter int DATA_SIZE_ARB = DATA_SIZE_ARB_DEF,
    parameter int PE_NUMBER     = PE_NUMBER_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PAIR_BITS-1:0]               cycle,
    input  logic [DATA_SIZE_ARB*PE_NUMBER-1:0] data_in,
    output logic [DATA_SIZE_ARB*PE_NUMBER-1:0] data_out
);

    localparam int WORD_W = DATA_SIZE_ARB * PE_NUMBER;

    if (PE_NUMBER != 32 || DATA_SIZE_ARB < 1) begin : g_bad_cfg
        $error("bit_reverse: PE_NUMBER must be 32 and DATA_SIZE_ARB >= 1");
    end

    logic [WORD_W-1:0]    data_q;
    logic [PAIR_BITS-1:0] cycle_q;
    logic [WORD_W-1:0]    rot_word;
    logic [WORD_W-1:0]    perm_word;

    // cycle is captured alongside its word so rotation amounts can change every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            cycle_q <= '0;
        end else begin
            data_q  <= data_in;
            cycle_q <= cycle;
        end
    end

    pair_rotate #(
        .DATA_SIZE_ARB (DATA_SIZE_ARB),
        .PE_NUMBER     (PE_NUMBER)
    ) u_pair_rotate (
        .cycle    (cycle_q),
        .data_in  (data_q),
        .data_out (rot_word)
    );

    for (genvar d = 0; d < PE_NUMBER; d++) begin : g_bitrev
        localparam logic [LANE_BITS-1:0] OUT_LANE = bitrev5(LANE_BITS'(d));
        assign perm_word[OUT_LANE*DATA_SIZE_ARB +: DATA_SIZE_ARB] =
            rot_word[d*DATA_SIZE_ARB +: DATA_SIZE_ARB];
    end

`ifdef BITREV_OUT_REG_EN
    logic [WORD_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= perm_word;
        end
    end

    assign data_out = out_q;
`else
    // Zeroed input register permutes to zero, so reset still yields an all-zero output.
    assign data_out = perm_word;
`endif

endmodule

// File: tb/tb_bit_reverse.sv
// Scoreboard bench for bit_reverse: driver pushes expected words tagged with their due edge,
// a negedge monitor pops and compares. Build with or without BITREV_OUT_REG_EN.
module tb_bit_reverse;

    localparam int W  = 16;
    localparam int N  = 32;
    localparam int TW = W * N;
`ifdef BITREV_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Hand-tabulated 5-bit reversal of 0..31.
    localparam int BR [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                               1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    logic          clk;
    logic          reset;
    logic [3:0]    cycle;
    logic [TW-1:0] data_in;
    logic [TW-1:0] data_out;

    logic [TW-1:0] exp_q [$];
    int            due_q [$];
    string         name_q [$];

    int edge_cnt = 0;
    int n_checks = 0;
    int n_pass   = 0;

    bit_reverse #(
        .DATA_SIZE_ARB (W),
        .PE_NUMBER     (N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cycle    (cycle),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Clock / edge counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference mapping: out[bitrev5({(p+c) mod 16, b})] = in[{p, b}]
    function automatic logic [TW-1:0] model(input logic [TW-1:0] w, input logic [3:0] c);
        logic [TW-1:0] r;
        int p, b, d;
        r = '0;
        for (int i = 0; i < N; i++) begin
            p = i / 2;
            b = i % 2;
            d = ((p + int'(c)) % 16) * 2 + b;
            r[BR[d]*W +: W] = w[i*W +: W];
        end
        return r;
    endfunction

    // Driver tasks
    task automatic push_exp(input logic [TW-1:0] e, input int due, input string name);
        exp_q.push_back(e);
        due_q.push_back(due);
        name_q.push_back(name);
    endtask

    task automatic send(input logic [TW-1:0] w, input logic [3:0] c,
                        input logic [TW-1:0] e, input string name);
        @(negedge clk);
        reset   = 1'b0;
        data_in = w;
        cycle   = c;
        push_exp(e, edge_cnt + LAT, name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        data_in = {16{32'hDEAD_BEEF}};
        cycle   = 4'h9;
        while (due_q.size() > 0 && due_q[$] > edge_cnt) begin
            void'(exp_q.pop_back());
            void'(due_q.pop_back());
            void'(name_q.pop_back());
        end
        push_exp('0, edge_cnt + 1, "rst_zero");
        if (LAT == 2) push_exp('0, edge_cnt + 2, "rst_zero_outreg");
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= edge_cnt) begin
            n_checks++;
            if (due_q[0] == edge_cnt && data_out === exp_q[0]) begin
                n_pass++;
            end else begin
                $display("FAIL %s due %0d at %0d: got %h expected %h",
                         name_q[0], due_q[0], edge_cnt, data_out, exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    // Stimulus
    initial begin : stim
        logic [TW-1:0] w;
        logic [TW-1:0] e;
        logic [3:0]    c;
        int            v;

        reset   = 1'b1;
        cycle   = '0;
        data_in = '0;

        do_reset();

        // Identity tag, cycle 0: out[bitrev5(i)] = i
        w = '0;
        e = '0;
        for (int i = 0; i < N; i++) begin
            w[i*W +: W] = W'(i);
            e[BR[i]*W +: W] = W'(i);
        end
        send(w, 4'd0, e, "tag_c0");

        // cycle 3: lane0 -> d6 -> out12, lane1 -> d7 -> out28
        w = '0;
        e = '0;
        w[0*W +: W]  = 16'h000A;
        w[1*W +: W]  = 16'h000B;
        e[12*W +: W] = 16'h000A;
        e[28*W +: W] = 16'h000B;
        send(w, 4'd3, e, "c3_pair");

        // Wrap, cycle 15: lane2 -> d0 -> out0, lane3 -> d1 -> out16
        w = '0;
        e = '0;
        w[2*W +: W]  = 16'h0005;
        w[3*W +: W]  = 16'h0006;
        e[0*W +: W]  = 16'h0005;
        e[16*W +: W] = 16'h0006;
        send(w, 4'd15, e, "wrap_c15");

        // Highest pair, cycle 1: lane30 (p15) -> d0 -> out0, lane31 -> d1 -> out16
        w = '0;
        e = '0;
        w[30*W +: W] = 16'hC0DE;
        w[31*W +: W] = 16'hBEEF;
        e[0*W +: W]  = 16'hC0DE;
        e[16*W +: W] = 16'hBEEF;
        send(w, 4'd1, e, "wrap_c1");

        // Streaming sweep, back to back with a new cycle every word
        for (int n = 0; n < 32; n++) begin
            c = 4'(n);
            w = '0;
            for (int k = 0; k < N; k++) begin
                v = ((n >> 4) << 9) | ((((k >> 1) + (n & 15)) % 16) << 5) | k;
                w[k*W +: W] = W'(v);
            end
            send(w, c, model(w, c), "sweep");
        end

        // Mid-stream reset
        w = '0;
        for (int k = 0; k < N; k++) w[k*W +: W] = W'(16'h1100 + k);
        send(w, 4'd7, model(w, 4'd7), "pre_rst_a");
        send(~w, 4'd2, model(~w, 4'd2), "pre_rst_b");
        do_reset();
        for (int k = 0; k < N; k++) w[k*W +: W] = W'(16'h5A00 + 3 * k);
        send(w, 4'd11, model(w, 4'd11), "post_rst");
        send(~w, 4'd6, model(~w, 4'd6), "post_rst_b");

        for (int k = 0; k < 20 && due_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (due_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: pending %0d expected 0", due_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
